intp_mu_sequencer: RTL and testbench

Sequencer and flow controller for the cubic Farrow interpolator datapath (19-bit float: sign[18], exp[17:10] bias 127, mantissa[9:0]).
- Accepts input samples through a valid/ready handshake and keeps the 4-tap sample window (m+2, m+1, m, m-1).
- Runs a fixed-point NCO that generates the fractional interval mu and converts it to float19.
- Decides when the window advances, replacing the fixed 9-cycle load counter with a programmable step.
- Presents {window, mu} to the interpolator through a registered valid/ready output stage.

---
 rtl/intp_pkg.sv | 21 ++
 rtl/intp_mu_fix2flt.sv | 38 +++
 rtl/intp_mu_sequencer.sv | 124 ++++++++++++
 tb/tb_intp_mu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intp_pkg.sv
// Shared definitions for the Farrow interpolator sequencer: float19 field layout,
// sequencer states and the default NCO step.
package intp_pkg;

    localparam int SIGN_BIT = 18;
    localparam int EXP_MSB  = 17;
    localparam int EXP_LSB  = 10;
    localparam int MAN_W    = 10;
    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = EXP_MSB - EXP_LSB + 1;

    // About 1/9 in 0.16 fixed point: nine outputs per input sample.
    localparam int unsigned STEP_INIT_DEF = 7282;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        RUN     = 2'd1,
        ADVANCE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/intp_mu_fix2flt.sv
// Converts an unsigned 0.FRAC_W fixed-point fraction to float19 by locating the
// leading one and normalising; the mantissa is truncated, never rounded.
module intp_mu_fix2flt
    import intp_pkg::*;
#(
    parameter int FRAC_W     = 16,
    parameter int DATA_WIDTH = 19
) (
    input  logic [FRAC_W-1:0]     fix,
    output logic [DATA_WIDTH-1:0] flt
);

    localparam int LEAD_W = $clog2(FRAC_W);

    logic [LEAD_W-1:0]         lead;
    logic [FRAC_W+MAN_W-2:0]   norm;

    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < FRAC_W; i++) begin
            if (fix[i]) begin
                lead = LEAD_W'(i);
            end
        end
    end

    // The leading one is shifted out of the top, leaving the fraction bits MSB-aligned.
    always_comb begin
        norm = {fix[FRAC_W-2:0], {MAN_W{1'b0}}} << (LEAD_W'(FRAC_W - 1) - lead);
        flt  = '0;
        if (fix != '0) begin
            flt[SIGN_BIT]        = 1'b0;
            flt[EXP_MSB:EXP_LSB] = EXP_W'(EXP_BIAS - FRAC_W) + EXP_W'(lead);
            flt[MAN_W-1:0]       = MAN_W'(norm >> (FRAC_W - 1));
        end
    end

endmodule

// File: rtl/intp_mu_sequencer.sv
// Sample-window sequencer and mu NCO for the cubic Farrow interpolator; issues
// {window, mu} tuples through a registered valid/ready output stage.
module intp_mu_sequencer
    import intp_pkg::*;
#(
    parameter int          DATA_WIDTH = 19,
    parameter int          FRAC_W     = 16,
    parameter int unsigned STEP_INIT  = STEP_INIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_load,
    input  logic [FRAC_W-1:0]     cfg_step,
    input  logic [FRAC_W-1:0]     cfg_mu0,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x0,
    output logic [DATA_WIDTH-1:0] out_x1,
    output logic [DATA_WIDTH-1:0] out_x2,
    output logic [DATA_WIDTH-1:0] out_x3,
    output logic [DATA_WIDTH-1:0] out_mu,
    output logic [15:0]           underrun_cnt
);

    seq_state_t            state;
    logic [2:0]            fill_cnt;
    logic [FRAC_W-1:0]     phase;
    logic [FRAC_W-1:0]     step;
    logic [DATA_WIDTH-1:0] win0, win1, win2, win3;
    logic [FRAC_W:0]       phase_sum;
    logic [DATA_WIDTH-1:0] mu_flt;
    logic                  accept;
    logic                  slot_free;

    intp_mu_fix2flt #(
        .FRAC_W     (FRAC_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fix2flt (
        .fix (phase),
        .flt (mu_flt)
    );

    // in_ready is combinational so a cfg_load cycle can refuse the sample it collides with.
    always_comb begin
        in_ready  = rst_n && !cfg_load && (state != RUN);
        accept    = in_valid && in_ready;
        slot_free = !out_valid || out_ready;
        phase_sum = {1'b0, phase} + {1'b0, step};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            fill_cnt     <= '0;
            phase        <= '0;
            step         <= FRAC_W'(STEP_INIT);
            win0         <= '0;
            win1         <= '0;
            win2         <= '0;
            win3         <= '0;
            out_valid    <= 1'b0;
            out_x0       <= '0;
            out_x1       <= '0;
            out_x2       <= '0;
            out_x3       <= '0;
            out_mu       <= '0;
            underrun_cnt <= '0;
        end else if (cfg_load) begin
            step      <= cfg_step;
            phase     <= cfg_mu0;
            fill_cnt  <= '0;
            state     <= FILL;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept) begin
                win3 <= win2;
                win2 <= win1;
                win1 <= win0;
                win0 <= in_data;
            end

            case (state)
                FILL: begin
                    if (accept) begin
                        fill_cnt <= fill_cnt + 3'd1;
                        if (fill_cnt == 3'd3) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (slot_free) begin
                        out_x0    <= win0;
                        out_x1    <= win1;
                        out_x2    <= win2;
                        out_x3    <= win3;
                        out_mu    <= mu_flt;
                        out_valid <= 1'b1;
                        phase     <= phase_sum[FRAC_W-1:0];
                        state     <= phase_sum[FRAC_W] ? ADVANCE : RUN;
                    end
                end
                ADVANCE: begin
                    if (accept) begin
                        state <= RUN;
                    end else if (underrun_cnt != '1) begin
                        underrun_cnt <= underrun_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intp_mu_sequencer.sv
// Directed and randomized bench for intp_mu_sequencer against a tuple-stream model:
// tuple j carries phase mu0 + j*step, and the window base advances by the carries so far.
module tb_intp_mu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cfg_load;
    logic [15:0] cfg_step;
    logic [15:0] cfg_mu0;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [18:0] out_x0, out_x1, out_x2, out_x3, out_mu;
    logic [15:0] underrun_cnt;

    intp_mu_sequencer #(
        .DATA_WIDTH (19),
        .FRAC_W     (16),
        .STEP_INIT  (7282)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_load     (cfg_load),
        .cfg_step     (cfg_step),
        .cfg_mu0      (cfg_mu0),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_x0       (out_x0),
        .out_x1       (out_x1),
        .out_x2       (out_x2),
        .out_x3       (out_x3),
        .out_mu       (out_mu),
        .underrun_cnt (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          failed = 0;
    logic [18:0] smp[$];
    int          m_step;
    int          m_mu0;
    int          tj;
    int          tuples_total = 0;

    localparam logic [18:0] SA = 19'h1F000;
    localparam logic [18:0] SB = 19'h20400;
    localparam logic [18:0] SC = 19'h3C000;
    localparam logic [18:0] SD = 19'h5A5A5;
    localparam logic [18:0] SE = 19'h7FFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Float value of p/65536, truncated to a 10-bit mantissa.
    function automatic logic [18:0] ref_flt(input int p);
        int k;
        int mant;
        int ex;
        logic [7:0] e8;
        logic [9:0] m10;
        if (p == 0) return 19'h0;
        k = 0;
        while ((p >> (k + 1)) != 0) k++;
        mant = ((p - (1 << k)) * 1024) >> k;
        ex   = 127 + k - 16;
        e8   = ex[7:0];
        m10  = mant[9:0];
        return {1'b0, e8, m10};
    endfunction

    task automatic model_reset(input int st, input int mu0);
        smp.delete();
        m_step = st;
        m_mu0  = mu0;
        tj     = 0;
    endtask

    task automatic check_tuple();
        longint acc;
        int     a;
        int     ph;
        acc = longint'(m_mu0) + longint'(tj) * longint'(m_step);
        a   = int'(acc >> 16);
        ph  = int'(acc & 64'hFFFF);
        if (smp.size() < a + 4) begin
            check("tuple_window_avail", smp.size(), a + 4);
        end else begin
            check("tuple_x0", out_x0, smp[a + 3]);
            check("tuple_x1", out_x1, smp[a + 2]);
            check("tuple_x2", out_x2, smp[a + 1]);
            check("tuple_x3", out_x3, smp[a]);
            check("tuple_mu", out_mu, ref_flt(ph));
        end
        tj++;
        tuples_total++;
    endtask

    // One clock: observe both handshakes just before the edge, then settle 1 after it.
    task automatic tick();
        logic        acc;
        logic [18:0] d;
        #1;
        if (rst_n && out_valid && out_ready) check_tuple();
        acc = in_valid && in_ready;
        d   = in_data;
        @(posedge clk);
        #1;
        if (acc) smp.push_back(d);
    endtask

    task automatic fill_to(input int target);
        int n;
        n = 0;
        in_valid = 1'b1;
        while (smp.size() < target && n < 40) begin
            in_data = 19'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("fill_count", smp.size(), target);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 19'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic do_cfg(input int st, input int mu0);
        cfg_load = 1'b1;
        cfg_step = 16'(st);
        cfg_mu0  = 16'(mu0);
        tick();
        cfg_load = 1'b0;
        model_reset(st, mu0);
        check("cfg_out_valid_clear", out_valid, 1'b0);
    endtask

    initial begin
        int n;
        logic [18:0] vec [4];
        vec[0] = SA; vec[1] = SB; vec[2] = SC; vec[3] = SD;

        rst_n = 1'b0; cfg_load = 1'b0; cfg_step = '0; cfg_mu0 = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_reset(7282, 0);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_underrun", underrun_cnt, 16'h0);
        check("rst_out_mu", out_mu, 19'h0);
        check("rst_out_x0", out_x0, 19'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill A..D with the output stage stalled.
        n = 0;
        in_valid = 1'b1;
        while (smp.size() < 4 && n < 20) begin
            in_data = vec[smp.size()];
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("fill_abcd", smp.size(), 4);
        check("latency_not_yet", out_valid, 1'b0);
        check("run_in_ready", in_ready, 1'b0);
        tick();
        check("first_valid", out_valid, 1'b1);
        check("first_x0", out_x0, SD);
        check("first_x1", out_x1, SC);
        check("first_x2", out_x2, SB);
        check("first_x3", out_x3, SA);
        check("first_mu", out_mu, 19'h00000);

        // Stall: tuple must hold and no sample may be taken.
        in_valid = 1'b1;
        in_data  = SE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", out_valid, 1'b1);
            check("stall_x0", out_x0, SD);
            check("stall_x3", out_x3, SA);
            check("stall_mu", out_mu, 19'h00000);
            check("stall_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        check("stall_no_accept", smp.size(), 4);

        out_ready = 1'b1;
        tick();
        check("second_valid", out_valid, 1'b1);
        check("second_mu", out_mu, 19'h1EF1C);

        n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        check("advance_reached", in_ready, 1'b1);
        repeat (3) tick();
        check("underrun_3", underrun_cnt, 16'd3);

        in_valid = 1'b1;
        in_data  = SE;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check("tenth_valid", out_valid, 1'b1);
        check("tenth_x0", out_x0, SE);
        check("tenth_x1", out_x1, SD);
        check("tenth_x2", out_x2, SC);
        check("tenth_x3", out_x3, SB);
        check("tenth_mu", out_mu, 19'h1C000);

        // cfg_load while in RUN with a sample offered.
        in_valid = 1'b1;
        in_data  = 19'($urandom);
        cfg_load = 1'b1;
        cfg_step = 16'h8000;
        cfg_mu0  = 16'h4000;
        #1;
        check("cfg_in_ready_low", in_ready, 1'b0);
        tick();
        cfg_load = 1'b0;
        model_reset(32'h8000, 32'h4000);
        check("cfg_out_valid_low", out_valid, 1'b0);
        fill_to(4);
        tick();
        check("half_first_valid", out_valid, 1'b1);
        check("half_mu_quarter", out_mu, 19'h1F400);
        tick();
        check("half_mu_three_q", out_mu, 19'h1FA00);
        rand_run(200);

        do_cfg($urandom_range(1, 65535), $urandom_range(0, 65535));
        rand_run(300);

        do_cfg(0, $urandom_range(0, 65535));
        fill_to(4);
        rand_run(40);
        check("step0_no_advance", in_ready, 1'b0);

        do_cfg(32'h2000, 0);
        rand_run(100);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_underrun", underrun_cnt, 16'h0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_out_mu", out_mu, 19'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset(7282, 0);
        out_ready = 1'b1;
        fill_to(3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("refill_no_tuple", out_valid, 1'b0);
        end
        fill_to(4);
        tick();
        check("refill_first_valid", out_valid, 1'b1);
        rand_run(200);
        check("tuples_flowed", tuples_total > 100, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
